// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the accumulator CPU control path.
//   - Opcode values as carried in the instruction register.
//   - ALU function codes driven on alu_op.
//   - Sequencer state encoding.
//   - Small helpers that classify an opcode. Callers pass the opcode
//     zero-extended to 32 bits, so the helpers work for any OPCODE_W.
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Instruction opcodes
    localparam int unsigned OPC_HALT  = 0;
    localparam int unsigned OPC_READ  = 1;
    localparam int unsigned OPC_WRITE = 2;
    localparam int unsigned OPC_JPNZ  = 3;
    localparam int unsigned OPC_CLAC  = 4;
    localparam int unsigned OPC_ADD   = 5;
    localparam int unsigned OPC_SUB   = 6;
    localparam int unsigned OPC_SHIFT = 7;
    localparam int unsigned OPC_INC   = 8;

    // ALU function codes
    localparam int unsigned ALU_CLAC  = 0;
    localparam int unsigned ALU_ADD   = 1;
    localparam int unsigned ALU_SUB   = 2;
    localparam int unsigned ALU_SHIFT = 3;
    localparam int unsigned ALU_INC   = 4;

    // Sequencer states.
    // F_*: instruction fetch, O_*: operand fetch, X_*: execute.
    typedef enum logic [3:0] {
        S_F_AR   = 4'd0,
        S_F_MEM  = 4'd1,
        S_F_IR   = 4'd2,
        S_DECODE = 4'd3,
        S_O_MEM  = 4'd4,
        S_O_LAT  = 4'd5,
        S_X_AR   = 4'd6,
        S_X_RD   = 4'd7,
        S_X_AC   = 4'd8,
        S_X_DR   = 4'd9,
        S_X_WR   = 4'd10,
        S_JMP    = 4'd11,
        S_SKIP   = 4'd12,
        S_ALU    = 4'd13,
        S_HALT   = 4'd14
    } cs_state_t;

    // True for the register-only ALU instructions.
    function automatic bit is_alu_opcode(input int unsigned opc);
        return (opc >= OPC_CLAC) && (opc <= OPC_INC);
    endfunction

    // Every value from HALT up to INC is defined; anything above traps.
    function automatic bit is_defined_opcode(input int unsigned opc);
        return opc <= OPC_INC;
    endfunction

    // ALU function selected by an ALU opcode.
    function automatic int unsigned alu_code(input int unsigned opc);
        case (opc)
            OPC_CLAC:  return ALU_CLAC;
            OPC_ADD:   return ALU_ADD;
            OPC_SUB:   return ALU_SUB;
            OPC_SHIFT: return ALU_SHIFT;
            OPC_INC:   return ALU_INC;
            default:   return ALU_CLAC;
        endcase
    endfunction

    // State that follows DECODE. An untaken JPNZ goes to SKIP, which steps
    // PC over the operand bytes without touching memory. Undefined opcodes
    // land in HALT; the caller records the trap separately.
    function automatic cs_state_t decode_target(input int unsigned opc,
                                                input logic        flag);
        case (opc)
            OPC_READ,
            OPC_WRITE: return S_O_MEM;
            OPC_JPNZ:  return flag ? S_O_MEM : S_SKIP;
            OPC_HALT:  return S_HALT;
            default:   return is_alu_opcode(opc) ? S_ALU : S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/cs_out_decode.sv
// ----------------------------------------------------------------------------
// cs_out_decode
//   Combinational decode from the sequencer state to the datapath control
//   strobes. Every output is a Moore function of the state, except that
//   pc_inc and dr_from_mem are gated by mem_ready in the memory states. That
//   way a wait state only ever shows mem_req (plus mem_we for a write).
//
// Ports
//   state        in   current sequencer state
//   mem_ready    in   memory completes the current request this cycle
//   opcode       in   IR contents, used to pick the ALU function
//   mem_req..alu_en   out  datapath strobes, one per register transfer
//   alu_op       out  ALU function, valid while alu_en is high, 0 otherwise
//   halted       out  sequencer sits in HALT
// ----------------------------------------------------------------------------
module cs_out_decode
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int ALU_OP_W = 3
) (
    input  cs_state_t            state,
    input  logic                 mem_ready,
    input  logic [OPCODE_W-1:0]  opcode,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ar_from_pc,
    output logic                 ar_from_tr,
    output logic                 pc_inc,
    output logic                 pc_from_tr,
    output logic                 dr_from_mem,
    output logic                 dr_from_ac,
    output logic                 ir_load,
    output logic                 tr_shift,
    output logic                 ac_from_dr,
    output logic                 alu_en,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 halted
);

    // Start from an all-quiet cycle and switch on the transfers of the
    // current state. DECODE and unused encodings drive nothing.
    always_comb begin
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        ar_from_pc  = 1'b0;
        ar_from_tr  = 1'b0;
        pc_inc      = 1'b0;
        pc_from_tr  = 1'b0;
        dr_from_mem = 1'b0;
        dr_from_ac  = 1'b0;
        ir_load     = 1'b0;
        tr_shift    = 1'b0;
        ac_from_dr  = 1'b0;
        alu_en      = 1'b0;
        alu_op      = '0;
        halted      = 1'b0;

        case (state)
            S_F_AR: begin
                ar_from_pc = 1'b1;
            end
            S_F_MEM, S_O_MEM: begin
                mem_req     = 1'b1;
                dr_from_mem = mem_ready;
                pc_inc      = mem_ready;
            end
            S_F_IR: begin
                ir_load    = 1'b1;
                ar_from_pc = 1'b1;
            end
            S_O_LAT: begin
                tr_shift   = 1'b1;
                ar_from_pc = 1'b1;
            end
            S_X_AR: begin
                ar_from_tr = 1'b1;
            end
            S_X_RD: begin
                mem_req     = 1'b1;
                dr_from_mem = mem_ready;
            end
            S_X_AC: begin
                ac_from_dr = 1'b1;
            end
            S_X_DR: begin
                dr_from_ac = 1'b1;
            end
            S_X_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            S_JMP: begin
                pc_from_tr = 1'b1;
            end
            S_SKIP: begin
                pc_inc = 1'b1;
            end
            S_ALU: begin
                alu_en = 1'b1;
                alu_op = ALU_OP_W'(alu_code(32'(opcode)));
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer
//   Multi-cycle control sequencer for the accumulator CPU. It fetches an
//   opcode, then ADDR_BYTES operand bytes (MSB first into TR), and executes
//   READ / WRITE / JPNZ / ALU / HALT. Memory accesses use a mem_req/mem_ready
//   handshake: a memory state holds until mem_ready is seen. An undefined
//   opcode halts the sequencer and raises the sticky illegal flag. Only
//   rst_n leaves HALT.
//
// Parameters
//   OPCODE_W    opcode width
//   ADDR_BYTES  operand bytes per memory/jump instruction, 1..4
//   ALU_OP_W    width of alu_op
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   opcode       IR contents, looked at in DECODE, O_LAT, X_AR and ALU
//   flag         JPNZ condition, looked at in DECODE only
//   mem_ready    memory completes the current request this cycle
//   mem_req..alu_op   datapath control strobes (see cs_out_decode)
//   halted       sequencer is in HALT
//   illegal      HALT was entered on an undefined opcode
// ----------------------------------------------------------------------------
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int ADDR_BYTES = 2,
    parameter int ALU_OP_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 flag,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 ar_from_pc,
    output logic                 ar_from_tr,
    output logic                 pc_inc,
    output logic                 pc_from_tr,
    output logic                 dr_from_mem,
    output logic                 dr_from_ac,
    output logic                 ir_load,
    output logic                 tr_shift,
    output logic                 ac_from_dr,
    output logic                 alu_en,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic                 halted,
    output logic                 illegal
);

    // The byte counter is one bit wider than the index needs, so that
    // ADDR_BYTES=1 still gets a legal 1-bit counter.
    localparam int CNT_W = $clog2(ADDR_BYTES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ADDR_BYTES - 1);

    cs_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             illegal_q;
    logic [31:0]      opc_ext;

    // Zero-extend the opcode so the package helpers work for any OPCODE_W.
    assign opc_ext = 32'(opcode);

    // State register, operand-byte counter and the sticky trap flag.
    // Memory states only advance on mem_ready. The counter saturates at
    // CNT_LAST, because the last operand byte and the last skipped byte both
    // leave the loop instead of counting on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_F_AR;
            cnt       <= '0;
            illegal_q <= 1'b0;
        end else begin
            case (state)
                S_F_AR: begin
                    state <= S_F_MEM;
                end
                S_F_MEM: begin
                    if (mem_ready) begin
                        state <= S_F_IR;
                    end
                end
                S_F_IR: begin
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    cnt   <= '0;
                    state <= decode_target(opc_ext, flag);
                    if (!is_defined_opcode(opc_ext)) begin
                        illegal_q <= 1'b1;
                    end
                end
                S_O_MEM: begin
                    if (mem_ready) begin
                        state <= S_O_LAT;
                    end
                end
                S_O_LAT: begin
                    if (cnt == CNT_LAST) begin
                        state <= (opc_ext == OPC_JPNZ) ? S_JMP : S_X_AR;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= S_O_MEM;
                    end
                end
                S_X_AR: begin
                    state <= (opc_ext == OPC_WRITE) ? S_X_DR : S_X_RD;
                end
                S_X_RD: begin
                    if (mem_ready) begin
                        state <= S_X_AC;
                    end
                end
                S_X_AC: begin
                    state <= S_F_AR;
                end
                S_X_DR: begin
                    state <= S_X_WR;
                end
                S_X_WR: begin
                    if (mem_ready) begin
                        state <= S_F_AR;
                    end
                end
                S_JMP: begin
                    state <= S_F_AR;
                end
                S_SKIP: begin
                    if (cnt == CNT_LAST) begin
                        state <= S_F_AR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ALU: begin
                    state <= S_F_AR;
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_F_AR;
                end
            endcase
        end
    end

    assign illegal = illegal_q;

    cs_out_decode #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_out_decode (
        .state       (state),
        .mem_ready   (mem_ready),
        .opcode      (opcode),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ar_from_pc  (ar_from_pc),
        .ar_from_tr  (ar_from_tr),
        .pc_inc      (pc_inc),
        .pc_from_tr  (pc_from_tr),
        .dr_from_mem (dr_from_mem),
        .dr_from_ac  (dr_from_ac),
        .ir_load     (ir_load),
        .tr_shift    (tr_shift),
        .ac_from_dr  (ac_from_dr),
        .alu_en      (alu_en),
        .alu_op      (alu_op),
        .halted      (halted)
    );

endmodule

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer
//   Three sequencers (ADDR_BYTES = 2, 1, 4) share clock and reset. Each one
//   has its own opcode/flag/mem_ready inputs. For every instruction the bench
//   writes out the expected per-cycle control word from the instruction's
//   micro-step recipe, and it chooses the memory wait states at random. The
//   run loop replays the inputs cycle by cycle and records the outputs. Each
//   test then compares what it recorded against the expected words.
// ----------------------------------------------------------------------------
module tb_control_sequencer;
    import cpu_pkg::*;

    localparam int NI     = 3;
    localparam int MAXLEN = 1024;

    // Control word layout:
    // {mem_req, mem_we, ar_from_pc, ar_from_tr, pc_inc, pc_from_tr,
    //  dr_from_mem, dr_from_ac, ir_load, tr_shift, ac_from_dr, alu_en,
    //  alu_op[2:0], halted, illegal}
    localparam logic [16:0] V_MREQ  = 17'h10000;
    localparam logic [16:0] V_MWE   = 17'h08000;
    localparam logic [16:0] V_ARPC  = 17'h04000;
    localparam logic [16:0] V_ARTR  = 17'h02000;
    localparam logic [16:0] V_PCINC = 17'h01000;
    localparam logic [16:0] V_PCTR  = 17'h00800;
    localparam logic [16:0] V_DRMEM = 17'h00400;
    localparam logic [16:0] V_DRAC  = 17'h00200;
    localparam logic [16:0] V_IRLD  = 17'h00100;
    localparam logic [16:0] V_TRSH  = 17'h00080;
    localparam logic [16:0] V_ACDR  = 17'h00040;
    localparam logic [16:0] V_ALUEN = 17'h00020;
    localparam logic [16:0] V_HALT  = 17'h00002;
    localparam logic [16:0] V_ILL   = 17'h00001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  opc_in  [NI];
    logic        flag_in [NI];
    logic        rdy_in  [NI];
    logic [16:0] outv    [NI];

    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NI; g++) begin : g_dut
            localparam int AB = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
            logic       mem_req, mem_we, ar_from_pc, ar_from_tr, pc_inc;
            logic       pc_from_tr, dr_from_mem, dr_from_ac, ir_load;
            logic       tr_shift, ac_from_dr, alu_en, halted, illegal;
            logic [2:0] alu_op;

            control_sequencer #(
                .OPCODE_W   (4),
                .ADDR_BYTES (AB),
                .ALU_OP_W   (3)
            ) u_dut (
                .clk         (clk),
                .rst_n       (rst_n),
                .opcode      (opc_in[g]),
                .flag        (flag_in[g]),
                .mem_ready   (rdy_in[g]),
                .mem_req     (mem_req),
                .mem_we      (mem_we),
                .ar_from_pc  (ar_from_pc),
                .ar_from_tr  (ar_from_tr),
                .pc_inc      (pc_inc),
                .pc_from_tr  (pc_from_tr),
                .dr_from_mem (dr_from_mem),
                .dr_from_ac  (dr_from_ac),
                .ir_load     (ir_load),
                .tr_shift    (tr_shift),
                .ac_from_dr  (ac_from_dr),
                .alu_en      (alu_en),
                .alu_op      (alu_op),
                .halted      (halted),
                .illegal     (illegal)
            );

            assign outv[g] = {mem_req, mem_we, ar_from_pc, ar_from_tr, pc_inc,
                              pc_from_tr, dr_from_mem, dr_from_ac, ir_load,
                              tr_shift, ac_from_dr, alu_en, alu_op, halted,
                              illegal};
        end
    endgenerate

    // Expected trace per instance: control word, plus the inputs to drive
    logic [16:0] exp_vec  [NI][MAXLEN];
    logic        exp_rdy  [NI][MAXLEN];
    logic [3:0]  exp_opc  [NI][MAXLEN];
    logic        exp_flag [NI][MAXLEN];
    logic [16:0] obs      [NI][MAXLEN];
    int          len      [NI];
    logic [3:0]  cur_opc  [NI];
    logic        cur_flag [NI];

    int checks = 0;
    int errors = 0;

    function automatic int ab_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
    endfunction

    function automatic logic [2:0] exp_alu(input int opc);
        case (opc)
            4:       return 3'(ALU_CLAC);
            5:       return 3'(ALU_ADD);
            6:       return 3'(ALU_SUB);
            7:       return 3'(ALU_SHIFT);
            default: return 3'(ALU_INC);
        endcase
    endfunction

    task automatic push(input int k, input logic [16:0] v, input logic r);
        if (len[k] < MAXLEN) begin
            exp_vec[k][len[k]]  = v;
            exp_rdy[k][len[k]]  = r;
            exp_opc[k][len[k]]  = cur_opc[k];
            exp_flag[k][len[k]] = cur_flag[k];
            len[k]++;
        end
    endtask

    // Non-memory cycle: mem_ready is a don't-care, so drive noise on it.
    task automatic push_free(input int k, input logic [16:0] v);
        push(k, v, 1'($urandom_range(0, 1)));
    endtask

    // One memory access: `waits` stall cycles, then the completing cycle.
    task automatic push_mem(input int k, input logic [16:0] v_wait,
                            input logic [16:0] v_done, input int waits);
        for (int i = 0; i < waits; i++) push(k, v_wait, 1'b0);
        push(k, v_wait | v_done, 1'b1);
    endtask

    // Expected trace of one instruction. Fetch and operand waits are drawn
    // from 0..fmax. The execute access uses xfix stalls when xfix >= 0.
    task automatic add_instr(input int k, input int opc, input bit flg,
                             input int fmax, input int xfix);
        int ab;
        int xw;
        ab = ab_of(k);
        cur_opc[k]  = 4'(opc);
        cur_flag[k] = flg;
        xw = (xfix >= 0) ? xfix : int'($urandom_range(0, fmax));
        push_free(k, V_ARPC);
        push_mem(k, V_MREQ, V_DRMEM | V_PCINC, int'($urandom_range(0, fmax)));
        push_free(k, V_IRLD | V_ARPC);
        push_free(k, '0);
        if (opc == 1 || opc == 2 || (opc == 3 && flg)) begin
            for (int b = 0; b < ab; b++) begin
                push_mem(k, V_MREQ, V_DRMEM | V_PCINC,
                         int'($urandom_range(0, fmax)));
                push_free(k, V_TRSH | V_ARPC);
            end
            if (opc == 3) begin
                push_free(k, V_PCTR);
            end else if (opc == 1) begin
                push_free(k, V_ARTR);
                push_mem(k, V_MREQ, V_DRMEM, xw);
                push_free(k, V_ACDR);
            end else begin
                push_free(k, V_ARTR);
                push_free(k, V_DRAC);
                push_mem(k, V_MREQ | V_MWE, '0, xw);
            end
        end else if (opc == 3) begin
            for (int b = 0; b < ab; b++) push_free(k, V_PCINC);
        end else if (opc >= 4 && opc <= 8) begin
            push_free(k, V_ALUEN | (17'(exp_alu(opc)) << 2));
        end else begin
            for (int i = 0; i < 20; i++)
                push_free(k, V_HALT | ((opc != 0) ? V_ILL : 17'h0));
        end
    endtask

    // Hold reset and clear all traces.
    task automatic begin_test();
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            rdy_in[k]  = 1'b0;
            opc_in[k]  = '0;
            flag_in[k] = 1'b0;
            len[k]     = 0;
        end
        repeat (2) @(negedge clk);
    endtask

    // Release reset, replay the traces and record the outputs 1 ns after
    // each falling edge.
    task automatic run_traces();
        int n;
        n = 0;
        for (int k = 0; k < NI; k++) if (len[k] > n) n = len[k];
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < NI; k++) begin
                if (i < len[k]) begin
                    opc_in[k]  = exp_opc[k][i];
                    flag_in[k] = exp_flag[k][i];
                    rdy_in[k]  = exp_rdy[k][i];
                end else begin
                    rdy_in[k] = 1'b0;
                end
            end
            #1;
            for (int k = 0; k < NI; k++) obs[k][i] = outv[k];
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        begin_test();
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (outv[k] !== V_ARPC) begin
                errors++;
                $display("[TB] FAIL reset ab=%0d: got %h expected %h",
                         ab_of(k), outv[k], V_ARPC);
            end
            rdy_in[k] = 1'b1;
            opc_in[k] = 4'hF;
        end
        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (outv[k] !== V_ARPC) begin
                errors++;
                $display("[TB] FAIL reset_held ab=%0d: got %h expected %h",
                         ab_of(k), outv[k], V_ARPC);
            end
        end
    endtask

    task automatic test_alu();
        begin_test();
        for (int k = 0; k < NI; k++) begin
            add_instr(k, 5, 1'($urandom_range(0, 1)), 0, -1);
            for (int op = 4; op <= 8; op++)
                add_instr(k, op, 1'($urandom_range(0, 1)), 1, -1);
        end
        run_traces();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < len[k]; i++) begin
                checks++;
                if (obs[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("[TB] FAIL alu ab=%0d cycle %0d: got %h expected %h",
                             ab_of(k), i, obs[k][i], exp_vec[k][i]);
                end
            end
    endtask

    task automatic test_read();
        begin_test();
        for (int k = 0; k < NI; k++) begin
            add_instr(k, 1, 1'b0, 0, -1);
            add_instr(k, 1, 1'b1, 2, -1);
        end
        run_traces();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < len[k]; i++) begin
                checks++;
                if (obs[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("[TB] FAIL read ab=%0d cycle %0d: got %h expected %h",
                             ab_of(k), i, obs[k][i], exp_vec[k][i]);
                end
            end
    endtask

    task automatic test_jpnz();
        begin_test();
        for (int k = 0; k < NI; k++) begin
            add_instr(k, 3, 1'b0, 0, -1);
            add_instr(k, 3, 1'b1, 0, -1);
            add_instr(k, 3, 1'b0, 2, -1);
            add_instr(k, 3, 1'b1, 2, -1);
        end
        run_traces();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < len[k]; i++) begin
                checks++;
                if (obs[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("[TB] FAIL jpnz ab=%0d cycle %0d: got %h expected %h",
                             ab_of(k), i, obs[k][i], exp_vec[k][i]);
                end
            end
    endtask

    task automatic test_write_wait();
        begin_test();
        for (int k = 0; k < NI; k++) begin
            add_instr(k, 2, 1'b0, 0, 3);
            add_instr(k, 5, 1'b0, 0, -1);
        end
        run_traces();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < len[k]; i++) begin
                checks++;
                if (obs[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("[TB] FAIL write_wait ab=%0d cycle %0d: got %h expected %h",
                             ab_of(k), i, obs[k][i], exp_vec[k][i]);
                end
            end
    endtask

    task automatic test_back_to_back();
        for (int round = 0; round < 3; round++) begin
            begin_test();
            for (int k = 0; k < NI; k++)
                for (int n = 0; n < 8; n++)
                    add_instr(k, int'($urandom_range(1, 8)),
                              1'($urandom_range(0, 1)), 3, -1);
            run_traces();
            for (int k = 0; k < NI; k++)
                for (int i = 0; i < len[k]; i++) begin
                    checks++;
                    if (obs[k][i] !== exp_vec[k][i]) begin
                        errors++;
                        $display("[TB] FAIL back_to_back r%0d ab=%0d cycle %0d: got %h expected %h",
                                 round, ab_of(k), i, obs[k][i], exp_vec[k][i]);
                    end
                end
        end
    endtask

    task automatic test_illegal();
        begin_test();
        for (int k = 0; k < NI; k++) begin
            add_instr(k, 5, 1'b0, 1, -1);
            add_instr(k, (k == 0) ? 15 : int'($urandom_range(9, 15)), 1'b1, 1, -1);
        end
        run_traces();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < len[k]; i++) begin
                checks++;
                if (obs[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("[TB] FAIL illegal ab=%0d cycle %0d: got %h expected %h",
                             ab_of(k), i, obs[k][i], exp_vec[k][i]);
                end
            end
        // A reset pulse clears both halted and illegal.
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (outv[k] !== V_ARPC) begin
                errors++;
                $display("[TB] FAIL illegal_clear ab=%0d: got %h expected %h",
                         ab_of(k), outv[k], V_ARPC);
            end
        end
        begin_test();
        for (int k = 0; k < NI; k++) add_instr(k, 6, 1'b0, 1, -1);
        run_traces();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < len[k]; i++) begin
                checks++;
                if (obs[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("[TB] FAIL restart ab=%0d cycle %0d: got %h expected %h",
                             ab_of(k), i, obs[k][i], exp_vec[k][i]);
                end
            end
    endtask

    task automatic test_halt();
        begin_test();
        for (int k = 0; k < NI; k++) begin
            add_instr(k, 1, 1'b0, 1, -1);
            add_instr(k, 0, 1'b1, 1, -1);
        end
        run_traces();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < len[k]; i++) begin
                checks++;
                if (obs[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("[TB] FAIL halt ab=%0d cycle %0d: got %h expected %h",
                             ab_of(k), i, obs[k][i], exp_vec[k][i]);
                end
            end
    endtask

    // Park the ab=2 instance in an operand wait, then pull rst_n in the
    // middle of a cycle. The request must drop before any clock edge.
    task automatic test_reset_mid_wait();
        begin_test();
        opc_in[0] = 4'd1;
        rdy_in[0] = 1'b1;
        rst_n     = 1'b1;
        repeat (3) @(negedge clk);
        rdy_in[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (outv[0] !== V_MREQ) begin
                errors++;
                $display("[TB] FAIL mid_wait_hold cycle %0d: got %h expected %h",
                         i, outv[0], V_MREQ);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outv[0] !== V_ARPC) begin
            errors++;
            $display("[TB] FAIL mid_wait_reset: got %h expected %h",
                     outv[0], V_ARPC);
        end
        @(negedge clk);
        #1;
        checks++;
        if (outv[0] !== V_ARPC) begin
            errors++;
            $display("[TB] FAIL mid_wait_reset_held: got %h expected %h",
                     outv[0], V_ARPC);
        end
        begin_test();
        for (int k = 0; k < NI; k++) add_instr(k, 1, 1'b0, 0, -1);
        run_traces();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < len[k]; i++) begin
                checks++;
                if (obs[k][i] !== exp_vec[k][i]) begin
                    errors++;
                    $display("[TB] FAIL mid_wait_restart ab=%0d cycle %0d: got %h expected %h",
                             ab_of(k), i, obs[k][i], exp_vec[k][i]);
                end
            end
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            opc_in[k]   = '0;
            flag_in[k]  = 1'b0;
            rdy_in[k]   = 1'b0;
            len[k]      = 0;
            cur_opc[k]  = '0;
            cur_flag[k] = 1'b0;
        end
        $display("[TB] control_sequencer bench start");
        test_reset();
        test_alu();
        test_read();
        test_jpnz();
        test_write_wait();
        test_back_to_back();
        test_illegal();
        test_halt();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
